// File: rtl/sp_wb_pkg.sv
// sp_wb_pkg: shared types and constants for the service-processor Wishbone arbiter.
package sp_wb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;
  localparam int SP_WB_ADR_W = 24;
  localparam int SP_WB_DAT_W = 8;
  localparam logic [SP_WB_DAT_W-1:0] TIMEOUT_DATA = 8'hFF;
endpackage

// File: rtl/sp_wb_arb_timer.sv
// sp_wb_arb_timer: stalled-strobe counter; o_tc pulses for one cycle when the
// count reaches TIMEOUT_CYCLES, then the count restarts from zero.
module sp_wb_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_stall,
  output logic o_tc
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  assign o_tc = r_cnt == CNT_W'(TIMEOUT_CYCLES);
  always_ff @(posedge clk) begin
    if (reset || i_clr || o_tc) r_cnt <= '0;
    else if (i_stall) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/sp_wb_arbiter.sv
// sp_wb_arbiter: two-master round-robin Wishbone arbiter granting whole cyc tenures.
// Define SP_WB_ARB_TIMEOUT_EN to add a forced 0xFF ack after TIMEOUT_CYCLES stalled cycles.
module sp_wb_arbiter
  import sp_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int ADR_W = SP_WB_ADR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADR_W-1:0]       m0_adr_i,
  input  logic [SP_WB_DAT_W-1:0] m0_dat_i,
  input  logic                   m0_we_i,
  input  logic                   m0_sel_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_cyc_i,
  output logic [SP_WB_DAT_W-1:0] m0_dat_o,
  output logic                   m0_ack_o,
  input  logic [ADR_W-1:0]       m1_adr_i,
  input  logic [SP_WB_DAT_W-1:0] m1_dat_i,
  input  logic                   m1_we_i,
  input  logic                   m1_sel_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_cyc_i,
  output logic [SP_WB_DAT_W-1:0] m1_dat_o,
  output logic                   m1_ack_o,
  output logic [ADR_W-1:0]       s_adr_o,
  output logic [SP_WB_DAT_W-1:0] s_dat_o,
  output logic                   s_we_o,
  output logic                   s_sel_o,
  output logic                   s_stb_o,
  output logic                   s_cyc_o,
  input  logic [SP_WB_DAT_W-1:0] s_dat_i,
  input  logic                   s_ack_i,
  output logic [1:0]             owner_o,
  output logic                   timeout_o
);
  arb_state_t r_state, w_next;
  logic r_last, w_last_next;
  logic w_own0, w_own1, w_stb, w_force, w_ack;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
    end
  end
  always_comb begin
    w_next = r_state;
    w_last_next = r_last;
    case (r_state)
      ARB_IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
          w_next = ARB_OWN0;
          w_last_next = 1'b0;
        end else if (m1_cyc_i) begin
          w_next = ARB_OWN1;
          w_last_next = 1'b1;
        end
      end
      ARB_OWN0: w_next = m0_cyc_i ? ARB_OWN0 : ARB_IDLE;
      ARB_OWN1: w_next = m1_cyc_i ? ARB_OWN1 : ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end
  // Gating ownership with reset aborts a tenure in the cycle reset is raised.
  assign w_own0 = r_state == ARB_OWN0 && !reset;
  assign w_own1 = r_state == ARB_OWN1 && !reset;
  assign w_stb  = (w_own0 && m0_stb_i && m0_cyc_i) || (w_own1 && m1_stb_i && m1_cyc_i);
  assign w_ack  = s_ack_i || w_force;
  assign owner_o  = {w_own1, w_own0};
  assign s_cyc_o  = (w_own0 && m0_cyc_i) || (w_own1 && m1_cyc_i);
  assign s_stb_o  = w_stb && !w_force;
  assign s_adr_o  = w_own0 ? m0_adr_i : w_own1 ? m1_adr_i : '0;
  assign s_dat_o  = w_own0 ? m0_dat_i : w_own1 ? m1_dat_i : '0;
  assign s_we_o   = w_own0 ? m0_we_i  : w_own1 && m1_we_i;
  assign s_sel_o  = w_own0 ? m0_sel_i : w_own1 && m1_sel_i;
  assign m0_ack_o = w_own0 && m0_stb_i && w_ack;
  assign m1_ack_o = w_own1 && m1_stb_i && w_ack;
  assign m0_dat_o = w_force ? TIMEOUT_DATA : s_dat_i;
  assign m1_dat_o = m0_dat_o;
`ifdef SP_WB_ARB_TIMEOUT_EN
  logic r_timeout;
  sp_wb_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (r_state == ARB_IDLE || s_ack_i),
    .i_stall(w_stb && !s_ack_i),
    .o_tc   (w_force)
  );
  always_ff @(posedge clk) begin
    if (reset) r_timeout <= 1'b0;
    else if (w_force) r_timeout <= 1'b1;
  end
  assign timeout_o = r_timeout;
`else
  assign w_force   = 1'b0;
  assign timeout_o = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif
endmodule

// File: tb/tb_sp_wb_arbiter.sv
// tb_sp_wb_arbiter: vector table, directed corner sequences and a random run
// checked against a cycle-level model of the arbitration rules.
module tb_sp_wb_arbiter;
  localparam int TO_CYC = 16;
`ifdef SP_WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [23:0] m0_adr = '0, m1_adr = '0;
  logic [7:0] m0_dat = '0, m1_dat = '0, s_dat = '0;
  logic m0_we = 0, m0_sel = 0, m0_stb = 0, m0_cyc = 0;
  logic m1_we = 0, m1_sel = 0, m1_stb = 0, m1_cyc = 0, s_ack = 0;
  logic [7:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic m0_ack_o, m1_ack_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o, timeout_o;
  logic [23:0] s_adr_o;
  logic [1:0] owner_o;
  int n_vec = 0, n_err = 0;
  int mown, mlast, mcnt;
  bit mto;

  sp_wb_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .ADR_W(24)) dut (
    .clk(clk), .reset(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .owner_o(owner_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, c0, s0, c1, s1, ack;
    logic [1:0] own;
    bit scyc, a0, a1;
  } vec_t;
  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic model_check(input int cyc_n);
    int eo;
    bit f, oc, os, ack;
    logic [63:0] exp, act;
    eo  = rst ? 0 : mown;
    f   = TO_EN && mcnt == TO_CYC;
    oc  = eo == 1 ? m0_cyc : eo == 2 ? m1_cyc : 1'b0;
    os  = eo == 1 ? m0_stb : eo == 2 ? m1_stb : 1'b0;
    ack = s_ack || f;
    exp = {7'd0, (eo == 2), (eo == 1), oc, os && oc && !f,
           (eo == 1 ? m0_we : eo == 2 ? m1_we : 1'b0),
           (eo == 1 ? m0_sel : eo == 2 ? m1_sel : 1'b0),
           (eo == 1 ? m0_adr : eo == 2 ? m1_adr : 24'h0),
           (eo == 1 ? m0_dat : eo == 2 ? m1_dat : 8'h0),
           (eo == 1 && m0_stb && ack), (eo == 2 && m1_stb && ack),
           (f ? 8'hFF : s_dat), (f ? 8'hFF : s_dat), mto};
    act = {7'd0, owner_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
           m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o, timeout_o};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL rand cycle %0d: got %0h expected %0h", cyc_n, act, exp);
    end
  endtask

  task automatic model_step();
    bit f, oc, os;
    f  = TO_EN && mcnt == TO_CYC;
    oc = mown == 1 ? m0_cyc : mown == 2 ? m1_cyc : 1'b0;
    os = mown == 1 ? m0_stb : mown == 2 ? m1_stb : 1'b0;
    if (rst) begin
      mown = 0; mlast = 1; mcnt = 0; mto = 0;
    end else begin
      if (f) mto = 1;
      if (mown == 0 || f || s_ack) mcnt = 0;
      else if (os && oc) mcnt++;
      if (mown == 0) begin
        if (m0_cyc && (!m1_cyc || mlast == 1)) begin mown = 1; mlast = 0; end
        else if (m1_cyc) begin mown = 2; mlast = 1; end
      end else if (!oc) mown = 0;
    end
  endtask

  initial begin
    logic [7:0] got_q[$];
    logic [7:0] beat_dat[4];
    int bad1, w, got, t_stb, t_ack;
    beat_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    //             rst c0 s0 c1 s1 ack  own   scyc a0 a1
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 1, 1, 0, 2'b00, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 1, 1, 1, 2'b01, 1, 1, 0};
    tbl[3]  = '{0, 0, 0, 1, 1, 1, 2'b01, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 1, 2'b00, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 1, 1, 1, 2'b10, 1, 0, 1};
    tbl[6]  = '{0, 1, 1, 1, 0, 1, 2'b10, 1, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0, 0, 2'b10, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 0, 0, 1, 2'b01, 1, 1, 0};
    tbl[10] = '{1, 1, 1, 0, 0, 1, 2'b00, 0, 0, 0};
    tbl[11] = '{0, 1, 1, 1, 1, 0, 2'b00, 0, 0, 0};
    tbl[12] = '{0, 1, 1, 1, 1, 0, 2'b01, 1, 0, 0};
    tbl[13] = '{0, 1, 1, 1, 1, 1, 2'b01, 1, 1, 0};
    m0_adr = 24'h804000; m1_adr = 24'h802000;
    tick();
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1; s_ack = tbl[i].ack;
      #2;
      chk($sformatf("tbl[%0d]", i), {owner_o, s_cyc_o, m0_ack_o, m1_ack_o},
          {tbl[i].own, tbl[i].scyc, tbl[i].a0, tbl[i].a1});
      tick();
    end

    // m0 alone: four byte beats, two wait states each
    do_reset();
    chk("reset_owner", owner_o, 0);
    chk("reset_timeout", timeout_o, 0);
    bad1 = 0;
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 24'h804000;
    #1 chk("a_cyc_same_cycle", s_cyc_o, 0);
    tick();
    #1 chk("a_cyc_next_cycle", s_cyc_o, 1);
    for (int b = 0; b < 4; b++) begin
      m0_adr = 24'h804000 + 24'(b);
      for (int k = 0; k < 3; k++) begin
        s_ack = k == 2;
        s_dat = k == 2 ? beat_dat[b] : 8'h00;
        #1;
        if (k == 0) chk($sformatf("a_adr%0d", b), s_adr_o, 24'h804000 + 24'(b));
        if (m0_ack_o) got_q.push_back(m0_dat_o);
        if (m1_ack_o) bad1++;
        tick();
      end
    end
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1 chk("a_release", s_cyc_o, 0);
    chk("a_ack_count", got_q.size(), 4);
    for (int b = 0; b < 4 && b < got_q.size(); b++)
      chk($sformatf("a_rdata%0d", b), got_q[b], beat_dat[b]);
    chk("a_m1_acks", bad1, 0);
    tick();

    // simultaneous requests alternate, one idle cycle between tenures
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int t = 0; t < 6; t++) begin
      w = 0;
      while (owner_o == 2'b00 && w < 5) begin tick(); w++; end
      chk($sformatf("b_grant%0d", t), owner_o, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("b_gap%0d", t), w, 1);
      got = owner_o;
      tick();
      if (got == 1) begin m0_cyc = 0; m0_stb = 0; end
      else begin m1_cyc = 0; m1_stb = 0; end
      tick();
      chk($sformatf("b_idle%0d", t), owner_o, 0);
      if (got == 1) begin m0_cyc = 1; m0_stb = 1; end
      else begin m1_cyc = 1; m1_stb = 1; end
    end

    // m1 mid-burst write while m0 waits
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 24'h802000; m1_dat = 8'hA5; m1_we = 1; m1_sel = 1;
    m0_adr = 24'h804000;
    tick();
    m0_cyc = 1; m0_stb = 1;
    for (int k = 0; k < 4; k++) begin
      s_ack = 1;
      #1;
      chk("c_m0_noack", m0_ack_o, 0);
      chk("c_m1_ack", m1_ack_o, 1);
      chk("c_adr", s_adr_o, 24'h802000);
      chk("c_wdat", {s_we_o, s_dat_o}, {1'b1, 8'hA5});
      tick();
    end
    m1_cyc = 0; m1_stb = 0;
    #1 chk("c_drop_adr", s_adr_o, 24'h802000);
    chk("c_drop_m0ack", m0_ack_o, 0);
    tick();
    chk("c_idle_adr", s_adr_o, 0);
    tick();
    chk("c_m0_adr", s_adr_o, 24'h804000);
    chk("c_m0_ack", m0_ack_o, 1);
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();

    // reset in the middle of an OWN0 beat
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    tick();
    chk("d_owned", owner_o, 2'b01);
    s_ack = 1; rst = 1;
    #1 chk("d_ack_during_reset", m0_ack_o, 0);
    tick();
    rst = 0;
    chk("d_after", {s_cyc_o, owner_o, m0_ack_o}, 4'b0000);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();

    // stalled slave
    do_reset();
    m0_cyc = 1; m0_stb = 1; s_ack = 0; s_dat = 8'h5A;
    t_stb = -1; t_ack = -1; got = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (s_stb_o && t_stb < 0) t_stb = i;
      if (m0_ack_o) begin t_ack = i; got = m0_dat_o; break; end
      tick();
    end
    if (TO_EN) begin
      chk("e_latency", t_ack - t_stb, TO_CYC);
      chk("e_data", got, 8'hFF);
      chk("e_stb_suppressed", s_stb_o, 0);
      tick();
      chk("e_flag", timeout_o, 1);
      for (int i = 0; i < 20; i++) tick();
      chk("e_flag_sticky", timeout_o, 1);
    end else begin
      chk("e_noack", t_ack, -1);
      chk("e_flag_off", timeout_o, 0);
    end
    m0_cyc = 0; m0_stb = 0;
    tick();

    // random traffic against the model
    do_reset();
    mown = 0; mlast = 1; mcnt = 0; mto = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 7) == 0) m1_cyc = ~m1_cyc;
      m0_stb = $urandom_range(0, 2) != 0;
      m1_stb = $urandom_range(0, 2) != 0;
      s_ack  = $urandom_range(0, 4) == 0;
      m0_adr = 24'($urandom); m1_adr = 24'($urandom);
      m0_dat = 8'($urandom); m1_dat = 8'($urandom); s_dat = 8'($urandom);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_sel = 1'($urandom); m1_sel = 1'($urandom);
      #2;
      model_check(i);
      model_step();
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
